// File: rtl/tile_cfg_pkg.sv
// rtl/tile_cfg_pkg.sv - shared types and constants for the tile configuration controller
package tile_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RECOVER,
        ST_CHECK,
        ST_DONE
    } tile_cfg_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int num_words_of(input int num_bits, input int data_w);
        return (num_bits + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/tile_cfg_crc16.sv
// rtl/tile_cfg_crc16.sv - CRC-16-CCITT over DATA_W-bit words, LSB first, registered result
module tile_cfg_crc16 import tile_cfg_pkg::*; #(
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [15:0]       crc
);

    logic [15:0] crc_next;

    // Fold a whole word into the running CRC, data bit 0 first
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < DATA_W; i++) begin
            if (crc_next[15] ^ data[i]) begin
                crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[14:0], 1'b0};
            end
        end
    end

    // CRC register: re-seeded on reset/clear, advanced once per accepted word
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/tile_cfg_ctrl.sv
// rtl/tile_cfg_ctrl.sv - tile bl/wl configuration controller; CRC trailer check under TILE_CFG_CRC_EN
module tile_cfg_ctrl import tile_cfg_pkg::*; #(
    parameter int NUM_BITS = 1260,
    parameter int DATA_W   = 20,
    parameter int WL_PULSE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [0:NUM_BITS-1] bl,
    output logic [0:NUM_BITS-1] wl,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int NUM_WORDS = num_words_of(NUM_BITS, DATA_W);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PAD_W     = NUM_WORDS * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);
    localparam logic [3:0]       PULSE_INIT = 4'(WL_PULSE);

`ifdef TILE_CFG_CRC_EN
    localparam tile_cfg_state_t AFTER_LAST = ST_CHECK;
`else
    localparam tile_cfg_state_t AFTER_LAST = ST_DONE;
`endif

    tile_cfg_state_t   state;
    tile_cfg_state_t   state_next;
    logic [IDX_W-1:0]  word_idx;
    logic [3:0]        pulse_cnt;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              pass_start;
    logic              drive_bl;
    logic              drive_wl;
    logic [31:0]       shift_amt;
    logic [NUM_BITS-1:0] slice_data;
    logic [NUM_BITS-1:0] slice_mask;

    assign accept     = cfg_valid && cfg_ready;
    assign pass_start = (state == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start outside IDLE is ignored by construction
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_LOAD;
            ST_LOAD:    if (accept) state_next = ST_WRITE;
            ST_WRITE:   if (pulse_cnt <= 4'd1) state_next = ST_RECOVER;
            ST_RECOVER: state_next = (word_idx == LAST_IDX) ? AFTER_LAST : ST_LOAD;
            ST_CHECK:   if (accept) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Word index, strobe-width counter and the word being written
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx  <= '0;
            pulse_cnt <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) word_idx <= '0;
                end
                ST_LOAD: begin
                    if (accept) begin
                        data_q    <= cfg_data;
                        pulse_cnt <= PULSE_INIT;
                    end
                end
                ST_WRITE:   pulse_cnt <= pulse_cnt - 4'd1;
                ST_RECOVER: word_idx  <= word_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        cfg_ready = (state == ST_LOAD) || (state == ST_CHECK);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        drive_bl  = (state == ST_WRITE) || (state == ST_RECOVER);
        drive_wl  = (state == ST_WRITE);
    end

    // Place the held word at its slice; bits past NUM_BITS fall off the truncation
    assign shift_amt  = 32'(word_idx) * 32'(DATA_W);
    assign slice_data = NUM_BITS'(PAD_W'(data_q) << shift_amt);
    assign slice_mask = NUM_BITS'(PAD_W'({DATA_W{1'b1}}) << shift_amt);

    for (genvar b = 0; b < NUM_BITS; b++) begin : g_lines
        assign bl[b] = drive_bl & slice_data[b];
        assign wl[b] = drive_wl & slice_mask[b];
    end

`ifdef TILE_CFG_CRC_EN
    logic [15:0] crc;
    logic [15:0] trailer;

    assign trailer = 16'(cfg_data);

    tile_cfg_crc16 #(.DATA_W(DATA_W)) u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (pass_start),
        .en    ((state == ST_LOAD) && accept),
        .data  (cfg_data),
        .crc   (crc)
    );

    // Sticky mismatch flag, cleared only by reset or the next pass
    always_ff @(posedge clk) begin
        if (reset || pass_start) begin
            error <= 1'b0;
        end else if ((state == ST_CHECK) && accept && (trailer != crc)) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_tile_cfg_ctrl.sv
// tb/tb_tile_cfg_ctrl.sv - self-checking bench for tile_cfg_ctrl (default and TILE_CFG_CRC_EN builds)
module tb_tile_cfg_ctrl;

    localparam int NB0 = 1260;
    localparam int NW0 = 63;
`ifdef TILE_CFG_CRC_EN
    localparam int CRC_X = 1;
`else
    localparam int CRC_X = 0;
`endif
    localparam int BASE_DONE = 191 + CRC_X;

    typedef struct {
        int         stall_word;
        int         stall_len;
        int         glitch_word;
        int         reset_word;
        logic [19:0] xmask;
        logic       crc_bad;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [29:0] wl;
        logic [29:0] bl;
        logic        ready;
        logic        done;
        logic        busy;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic start0 = 1'b0, valid0 = 1'b0;
    logic [19:0] data0 = '0;
    logic ready0, busy0, done0, error0;
    logic [0:NB0-1] bl0, wl0;
    logic [NB0-1:0] bl0_le, wl0_le;

    logic start1 = 1'b0, valid1 = 1'b0;
    logic [19:0] data1 = '0;
    logic ready1, busy1, done1, error1;
    logic [0:29] bl1, wl1;
    logic [29:0] bl1_le, wl1_le;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign bl0_le = {<<{bl0}};
    assign wl0_le = {<<{wl0}};
    assign bl1_le = {<<{bl1}};
    assign wl1_le = {<<{wl1}};

    tile_cfg_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .cfg_data(data0), .cfg_valid(valid0),
        .cfg_ready(ready0), .bl(bl0), .wl(wl0), .busy(busy0), .done(done0), .error(error0)
    );

    tile_cfg_ctrl #(.NUM_BITS(30), .DATA_W(20), .WL_PULSE(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .cfg_data(data1), .cfg_valid(valid1),
        .cfg_ready(ready1), .bl(bl1), .wl(wl1), .busy(busy1), .done(done1), .error(error1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [19:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 20; i++) begin
            fb = r[15] ^ d[i];
            r = {r[14:0], fb};
            r[5] = r[5] ^ fb;
            r[12] = r[12] ^ fb;
        end
        return r;
    endfunction

    function automatic logic [19:0] word_val(input int s, input logic [19:0] xm);
        return 20'(s) ^ xm;
    endfunction

    function automatic logic [19:0] slice0(input logic [NB0-1:0] v, input int s);
        return 20'(v >> (s * 20));
    endfunction

    function automatic logic [NB0-1:0] mask0(input int s);
        return {{(NB0-20){1'b0}}, 20'hFFFFF} << (s * 20);
    endfunction

    task automatic run_pass(input vec_t v, inout logic prev_err);
        int cyc, next_word, stall_left, active, prev_active, exp_slice;
        int runs, holds, runlen, nact, bad, stall_bad, done_cyc;
        logic [15:0] crc;
        logic [19:0] w;
        cyc = 0; next_word = 0; stall_left = v.stall_len; prev_active = -1; exp_slice = 0;
        runs = 0; holds = 0; runlen = 0; bad = 0; stall_bad = 0; done_cyc = -1;
        crc = 16'hFFFF;

        @(negedge clk);
        check("idle_busy", 64'(busy0), 0);
        check("error_sticky", 64'(error0), 64'(prev_err));
        start0 = 1'b1;
        valid0 = 1'b1;
        data0 = 20'($urandom);
        cyc = 1;

        while (cyc < 600 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start0 = 1'b0;
            if (cyc == 2) check("error_cleared", 64'(error0), 0);

            nact = 0;
            active = -1;
            for (int s = 0; s < NW0; s++) begin
                w = slice0(wl0_le, s);
                if (w != 20'h0) begin
                    nact++;
                    active = s;
                    if (w != 20'hFFFFF) bad++;
                end
            end
            if (nact > 1) bad++;

            if (active >= 0 && active == v.reset_word) begin
                reset = 1'b1;
                valid0 = 1'b0;
                @(negedge clk);
                check("rst_bl", 64'($countones(bl0_le)), 0);
                check("rst_wl", 64'($countones(wl0_le)), 0);
                check("rst_ready", 64'(ready0), 0);
                check("rst_busy", 64'(busy0), 0);
                check("rst_done", 64'(done0), 0);
                check("rst_error", 64'(error0), 0);
                reset = 1'b0;
                prev_err = 1'b0;
                return;
            end

            if (active >= 0) begin
                if (active != prev_active) begin
                    if (prev_active >= 0 || active != exp_slice) bad++;
                    exp_slice++;
                    runs++;
                    runlen = 0;
                end
                runlen++;
                if (slice0(bl0_le, active) != word_val(active, v.xmask) ||
                    (bl0_le & ~mask0(active)) != '0) bad++;
            end else if (prev_active >= 0) begin
                holds++;
                if (runlen != 1 || slice0(bl0_le, prev_active) != word_val(prev_active, v.xmask) ||
                    (bl0_le & ~mask0(prev_active)) != '0) bad++;
            end else if (bl0_le != '0) begin
                bad++;
            end
            prev_active = active;
            if (done0) done_cyc = cyc;

            if (ready0) begin
                if (next_word == v.stall_word && stall_left > 0) begin
                    valid0 = 1'b0;
                    stall_left--;
                    if (wl0_le != '0 || !busy0) stall_bad++;
                end else begin
                    valid0 = 1'b1;
                    if (next_word < NW0) begin
                        data0 = word_val(next_word, v.xmask);
                        crc = crc_word(crc, data0);
                    end else begin
                        data0 = {4'hA, crc ^ {15'd0, v.crc_bad}};
                    end
                    next_word++;
                end
            end else begin
                data0 = 20'($urandom);
                if (v.glitch_word >= 0 && active == v.glitch_word) start0 = 1'b1;
            end
        end

        check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        check("slice_runs", 64'(runs), 64'(NW0));
        check("hold_cycles", 64'(holds), 64'(NW0));
        check("bad_cycles", 64'(bad), 0);
        check("stall_bad", 64'(stall_bad), 0);
        check("error_at_done", 64'(error0), (CRC_X != 0) ? 64'(v.crc_bad) : 64'd0);
        @(negedge clk);
        valid0 = 1'b0;
        check("done_pulse_len", 64'(done0), 0);
        check("busy_after", 64'(busy0), 0);
        check("lines_after", 64'($countones(bl0_le) + $countones(wl0_le)), 0);
        prev_err = (CRC_X != 0) ? v.crc_bad : 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        row_t rows[16];
        logic prev_err;
        logic [15:0] trailer1;

        vecs[0] = '{-1, 0, -1, -1, 20'h00000, 1'b0, BASE_DONE};
        vecs[1] = '{5, 10, -1, -1, 20'h00000, 1'b0, BASE_DONE + 10};
        vecs[2] = '{-1, 0, 3, -1, 20'hAAAAA, 1'b1, BASE_DONE};
        vecs[3] = '{-1, 0, -1, -1, 20'hFFFFF, 1'b0, BASE_DONE};
        vecs[4] = '{-1, 0, -1, 7, 20'h55555, 1'b1, -1};
        vecs[5] = '{-1, 0, -1, -1, 20'h0F0F0, 1'b0, BASE_DONE};

        for (int k = 0; k < 16; k++) rows[k] = '{30'h0, 30'h0, 1'b0, 1'b0, 1'b0};
        rows[1] = '{30'h0, 30'h0, 1'b1, 1'b0, 1'b1};
        for (int k = 2; k <= 5; k++) rows[k] = '{30'h000FFFFF, 30'h00012345, 1'b0, 1'b0, 1'b1};
        rows[6] = '{30'h0, 30'h00012345, 1'b0, 1'b0, 1'b1};
        rows[7] = '{30'h0, 30'h0, 1'b1, 1'b0, 1'b1};
        for (int k = 8; k <= 11; k++) rows[k] = '{30'h3FF00000, 30'h3FF00000, 1'b0, 1'b0, 1'b1};
        rows[12] = '{30'h0, 30'h3FF00000, 1'b0, 1'b0, 1'b1};
`ifdef TILE_CFG_CRC_EN
        rows[13] = '{30'h0, 30'h0, 1'b1, 1'b0, 1'b1};
        rows[14] = '{30'h0, 30'h0, 1'b0, 1'b1, 1'b1};
`else
        rows[13] = '{30'h0, 30'h0, 1'b0, 1'b1, 1'b1};
`endif
        trailer1 = crc_word(crc_word(16'hFFFF, 20'h12345), 20'hFFFFF);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_bl0", 64'($countones(bl0_le)), 0);
        check("reset_wl0", 64'($countones(wl0_le)), 0);
        check("reset_ready0", 64'(ready0), 0);
        check("reset_busy0", 64'(busy0), 0);
        check("reset_done0", 64'(done0), 0);
        check("reset_error0", 64'(error0), 0);
        check("reset_bl1", 64'(bl1_le), 0);
        check("reset_wl1", 64'(wl1_le), 0);
        check("reset_busy1", 64'(busy1), 0);
        check("reset_error1", 64'(error1), 0);
        reset = 1'b0;

        prev_err = 1'b0;
        for (int i = 0; i < 6; i++) run_pass(vecs[i], prev_err);

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("small_wl", 64'(wl1_le), 64'(rows[k].wl));
            check("small_bl", 64'(bl1_le), 64'(rows[k].bl));
            check("small_ready", 64'(ready1), 64'(rows[k].ready));
            check("small_done", 64'(done1), 64'(rows[k].done));
            check("small_busy", 64'(busy1), 64'(rows[k].busy));
            start1 = (k == 0);
            valid1 = 1'b1;
            data1 = (k <= 1) ? 20'h12345 : (k <= 7) ? 20'hFFFFF : {4'h5, trailer1};
        end
        valid1 = 1'b0;
        start1 = 1'b0;
        check("small_error", 64'(error1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
